// File: rtl/sampler_voice_engine.sv
// Multi-voice sample playback engine.
// Once per output frame the voices are visited in turn: each voice drives its read
// pointer onto the shared memory address, and the returned stereo sample is summed
// into wide accumulators. The mix is then presented on left_out/right_out with a
// one-clock out_valid pulse.
// Optional build macro SAMPLER_SATURATE_EN: clamp the mix to the sample range
// instead of letting it wrap.
module sampler_voice_engine #(
    parameter int NUM_VOICES = 2,
    parameter int SAMPLE_W   = 24,
    parameter int ADDR_W     = 15,
    parameter int RATE_DIV   = 1134
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_VOICES-1:0]        trig,
    input  logic [NUM_VOICES-1:0]        loop,
    input  logic [NUM_VOICES*ADDR_W-1:0] start_addr,
    input  logic [NUM_VOICES*ADDR_W-1:0] end_addr,
    output logic [ADDR_W-1:0]            mem_addr,
    input  logic [SAMPLE_W-1:0]          mem_l,
    input  logic [SAMPLE_W-1:0]          mem_r,
    output logic [SAMPLE_W-1:0]          left_out,
    output logic [SAMPLE_W-1:0]          right_out,
    output logic                         out_valid,
    output logic [NUM_VOICES-1:0]        active
);

    localparam int CNT_W  = $clog2(RATE_DIV);
    localparam int VIDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam int ACC_W  = SAMPLE_W + 3;

    typedef enum logic [1:0] {StIdle, StAddr, StAcc, StOut} state_t;

    state_t                   state;
    logic [VIDX_W-1:0]        vidx;
    logic [CNT_W-1:0]         frame_cnt;
    logic                     tick;
    logic [NUM_VOICES-1:0]    trig_q;
    logic [NUM_VOICES-1:0]    pending;
    logic [NUM_VOICES-1:0]    trig_rise;
    logic [NUM_VOICES-1:0]    start_now;
    logic [ADDR_W-1:0]        ptr [NUM_VOICES];
    logic [ADDR_W-1:0]        cur_start;
    logic [ADDR_W-1:0]        cur_end;
    logic signed [ACC_W-1:0]  acc_l;
    logic signed [ACC_W-1:0]  acc_r;
    logic signed [ACC_W-1:0]  add_l;
    logic signed [ACC_W-1:0]  add_r;
    logic signed [ACC_W-1:0]  acc_l_next;
    logic signed [ACC_W-1:0]  acc_r_next;

`ifdef SAMPLER_SATURATE_EN
    // Clamp a wide mix value into the signed sample range.
    function automatic logic [SAMPLE_W-1:0] fit(input logic signed [ACC_W-1:0] v);
        logic signed [ACC_W-1:0] max_v;
        logic signed [ACC_W-1:0] min_v;
        max_v = {{4{1'b0}}, {(SAMPLE_W-1){1'b1}}};
        min_v = {{4{1'b1}}, {(SAMPLE_W-1){1'b0}}};
        if (v > max_v) begin
            return max_v[SAMPLE_W-1:0];
        end else if (v < min_v) begin
            return min_v[SAMPLE_W-1:0];
        end
        return v[SAMPLE_W-1:0];
    endfunction
`endif

    // Decode trigger edges, frame tick, current-voice config and accumulator inputs.
    always_comb begin
        tick       = (frame_cnt == '0);
        trig_rise  = trig & ~trig_q;
        // An edge arriving in the tick clock is honoured at that same tick.
        start_now  = tick ? (pending | trig_rise) : '0;
        cur_start  = start_addr[int'(vidx)*ADDR_W +: ADDR_W];
        cur_end    = end_addr[int'(vidx)*ADDR_W +: ADDR_W];
        mem_addr   = ptr[vidx];
        add_l      = '0;
        add_r      = '0;
        if (active[vidx]) begin
            add_l = {{3{mem_l[SAMPLE_W-1]}}, mem_l};
            add_r = {{3{mem_r[SAMPLE_W-1]}}, mem_r};
        end
        acc_l_next = acc_l + add_l;
        acc_r_next = acc_r + add_r;
    end

    // Free-running frame counter; count 0 is the tick.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame_cnt <= '0;
        end else if (frame_cnt == CNT_W'(RATE_DIV - 1)) begin
            frame_cnt <= '0;
        end else begin
            frame_cnt <= frame_cnt + CNT_W'(1);
        end
    end

    // Trigger edge capture; pending holds until consumed by the next tick.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            trig_q  <= '0;
            pending <= '0;
        end else begin
            trig_q  <= trig;
            pending <= (pending | trig_rise) & ~start_now;
        end
    end

    // Frame sequencer: voice start at tick, per-voice fetch/accumulate, mix output.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= StIdle;
            vidx      <= '0;
            acc_l     <= '0;
            acc_r     <= '0;
            active    <= '0;
            left_out  <= '0;
            right_out <= '0;
            out_valid <= 1'b0;
            for (int v = 0; v < NUM_VOICES; v++) begin
                ptr[v] <= '0;
            end
        end else begin
            out_valid <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (tick) begin
                        state <= StAddr;
                        vidx  <= '0;
                        acc_l <= '0;
                        acc_r <= '0;
                        // A retrigger wins over any end condition: it is applied
                        // before the voice is next accumulated.
                        for (int v = 0; v < NUM_VOICES; v++) begin
                            if (start_now[v]) begin
                                ptr[v]    <= start_addr[v*ADDR_W +: ADDR_W];
                                active[v] <= 1'b1;
                            end
                        end
                    end
                end
                StAddr: begin
                    state <= StAcc;
                end
                StAcc: begin
                    acc_l <= acc_l_next;
                    acc_r <= acc_r_next;
                    if (active[vidx]) begin
                        if (cur_start > cur_end) begin
                            // Inverted range plays its start sample once.
                            active[vidx] <= 1'b0;
                        end else if (ptr[vidx] == cur_end) begin
                            if (loop[vidx]) begin
                                ptr[vidx] <= cur_start;
                            end else begin
                                active[vidx] <= 1'b0;
                            end
                        end else begin
                            ptr[vidx] <= ptr[vidx] + ADDR_W'(1);
                        end
                    end
                    if (vidx == VIDX_W'(NUM_VOICES - 1)) begin
                        state     <= StOut;
                        out_valid <= 1'b1;
`ifdef SAMPLER_SATURATE_EN
                        left_out  <= fit(acc_l_next);
                        right_out <= fit(acc_r_next);
`else
                        left_out  <= acc_l_next[SAMPLE_W-1:0];
                        right_out <= acc_r_next[SAMPLE_W-1:0];
`endif
                    end else begin
                        state <= StAddr;
                        vidx  <= vidx + VIDX_W'(1);
                    end
                end
                StOut: begin
                    state <= StIdle;
                    vidx  <= '0;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule
